read_store_mc: RTL and testbench
================================

# read_store_mc

Parametrised batch read store for the SMEM pipeline. It buffers one batch of reads, loaded as 512-bit cache lines, together with their per-read parameter and initial-interval (ik) lines. Over a valid/ack handshake it hands each read's starting state to the forward pipeline. In parallel it serves NQ independent 3-stage symbol-query channels, which feed the query queues of multiple pipeline lanes.

## Interface
Parameters:
- CL, 512, cache-line width in bits
- MAX_READ, 512, maximum reads per batch
- READ_LINES, 2, sequence lines per read
- SYM_W, 8, bits per base symbol (CL divisible by 64, 64 divisible by SYM_W)
- NQ, 2, number of query channels
- Derived: RN_W = clog2(MAX_READ), SYMS = READ_LINES*CL/SYM_W, POS_W = clog2(SYMS), LPR = READ_LINES+2

Ports (all synchronous to clk; one clock; reset is synchronous and active-high):
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- batch_start  in  1  pulse: restart loading of a new batch
- batch_size  in  RN_W+1  reads in batch, 1..MAX_READ; sampled on batch_start
- load_valid  in  1  load_data beat valid
- load_data  in  CL  load line
- load_done  out  1  whole batch stored
- load_overflow  out  1  sticky: beat received after batch complete
- new_read_valid  out  1  new-read outputs valid
- new_read_ack  in  1  consumer takes current read
- new_read_num  out  RN_W  read index
- new_ik_x0, new_ik_x1, new_ik_x2, new_ik_info  out  64 each  ik line [63:0], [127:64], [191:128], [255:192]
- new_forward_i  out  7  param line [6:0]
- all_dispatched  out  1  every read of batch acked
- primary  out  64  read 0 param line [191:128]
- L2_0..L2_3  out  64 each  read 0 ik line [319:256], [383:320], [447:384], [511:448]
- q_status  in  NQ*6  per-channel status code
- q_position  in  NQ*POS_W  per-channel symbol index
- q_read_num  in  NQ*RN_W  per-channel read index
- q_symbol  out  NQ*SYM_W  per-channel result
- q_status_out  out  NQ*6  status aligned with q_symbol

## Operation
- Storage is LPR*MAX_READ lines, addressed {read, line}. The per-read load order is sequence lines 0..READ_LINES-1, then param, then ik.
- Load counters:
  - line_cnt runs 0..LPR-1 and wraps. On wrap read_cnt increments.
  - A load_valid beat writes to {read_cnt, line_cnt} only while read_cnt < batch_size.
  - Any beat when read_cnt == batch_size sets load_overflow and writes nothing.
- load_done is registered: it goes to 1 the cycle after read_cnt reaches batch_size (batch_size > 0).
- batch_start clears read_cnt, line_cnt, load_done, load_overflow, dispatch pointer and all_dispatched. Memory contents are kept. batch_start mid-load or mid-dispatch restarts cleanly. batch_start takes priority over a same-cycle load_valid, and that beat is dropped.
- Dispatch:
  - new_read_valid = load_done && ptr < batch_size (registered).
  - new_read_ack while valid increments ptr. Back-to-back acks are allowed, one read per cycle. Ack while not valid is ignored.
  - Unlike previous generation, the last read (index batch_size-1) is dispatched.
  - When ptr == batch_size, valid drops and all_dispatched is set.
  - While invalid, new_* outputs drive all-ones.
- Queries, per channel, independent:
  - Status is forwarded when it is 6'h30 (BUBBLE), 2 (F_break) or 6'h06 (BCK_END), or when position >= SYMS. In that case no lookup is done and the result is 8'hFF (all-ones of SYM_W).
  - Otherwise the channel returns symbol q_position of read q_read_num. Symbol k sits at bits [k*SYM_W +: SYM_W] of the concatenation {line READ_LINES-1, …, line 0}.
  - Stage 1 selects the line and latches its 256-bit half. Stage 2 selects a 64-bit word. Stage 3 selects the symbol.
- Reset values: load_done 0, load_overflow 0, new_read_valid 0, all_dispatched 0, q_symbol all-ones, q_status_out 6'h30.

## Timing
- Query latency is exactly 3 cycles for every channel. q_status_out equals q_status delayed 3 cycles, including filtered codes. One query per channel per cycle, fully pipelined.
- A query to a line written in the same cycle returns old data. A query issued one cycle later returns new data.
- new_* outputs are combinational from ptr. The next read appears the cycle after an ack.
- primary and L2_* are combinational from the read-0 lines and are valid once read 0 is loaded.
- reset overrides batch_start and all traffic.

## Test plan
- batch_size=3, 12 beats with data = beat index -> load_done rises 1 cycle after the 12th beat; read 1 param line = 6, its ik line = 7.
- Same batch, new_read_ack held high -> new_read_num 0,1,2 on consecutive cycles, then valid=0 and all_dispatched=1.
- Channel 0 queries read 2, positions 0, 63, 64, 127, with line 0 bytes = index and line 1 bytes = index+64 -> results 0, 63, 64, 127 exactly 3 cycles later, back-to-back.
- Channel 1 issues q_status=BUBBLE and position=SYMS, while channel 0 issues a valid query in the same cycle -> channel 1 returns 8'hFF with its status echoed, and channel 0 is unaffected.
- A 13th beat after the batch -> load_overflow=1 and read 2 is unchanged; then batch_start with batch_size=1 -> load_done=0, and a fresh 4-beat load completes.
- Assert reset mid-dispatch -> all outputs at reset values the next cycle; ptr restarts at 0 after reload.

Source files
------------

// File: rtl/read_store_mc_if.sv
// Load and dispatch bus of the batch read store.
// Master drives load beats and acks; slave is the store.
interface read_store_mc_if #(
  parameter int CL   = 512,
  parameter int RN_W = 9
);
  logic            batch_start;
  logic [RN_W:0]   batch_size;
  logic            load_valid;
  logic [CL-1:0]   load_data;
  logic            load_done;
  logic            load_overflow;
  logic            new_read_valid;
  logic            new_read_ack;
  logic [RN_W-1:0] new_read_num;
  logic [63:0]     new_ik_x0;
  logic [63:0]     new_ik_x1;
  logic [63:0]     new_ik_x2;
  logic [63:0]     new_ik_info;
  logic [6:0]      new_forward_i;
  logic            all_dispatched;

  modport master (
    output batch_start, batch_size, load_valid,
    output load_data, new_read_ack,
    input  load_done, load_overflow, new_read_valid,
    input  new_read_num, new_ik_x0, new_ik_x1,
    input  new_ik_x2, new_ik_info, new_forward_i,
    input  all_dispatched
  );

  modport slave (
    input  batch_start, batch_size, load_valid,
    input  load_data, new_read_ack,
    output load_done, load_overflow, new_read_valid,
    output new_read_num, new_ik_x0, new_ik_x1,
    output new_ik_x2, new_ik_info, new_forward_i,
    output all_dispatched
  );
endinterface

// File: rtl/read_store_mc.sv
// Batch read store: line loader, read dispatcher and
// NQ independent 3-stage symbol query channels.
module read_store_mc #(
  parameter int CL         = 512,
  parameter int MAX_READ   = 512,
  parameter int READ_LINES = 2,
  parameter int SYM_W      = 8,
  parameter int NQ         = 2,
  localparam int RN_W  = $clog2(MAX_READ),
  localparam int SYMS  = READ_LINES * CL / SYM_W,
  localparam int POS_W = $clog2(SYMS),
  localparam int LPR   = READ_LINES + 2
) (
  input  logic                  clk,
  input  logic                  reset,
  read_store_mc_if.slave        bus,
  output logic [63:0]           primary,
  output logic [63:0]           L2_0,
  output logic [63:0]           L2_1,
  output logic [63:0]           L2_2,
  output logic [63:0]           L2_3,
  input  logic [NQ*6-1:0]       q_status,
  input  logic [NQ*POS_W-1:0]   q_position,
  input  logic [NQ*RN_W-1:0]    q_read_num,
  output logic [NQ*SYM_W-1:0]   q_symbol,
  output logic [NQ*6-1:0]       q_status_out
);

  localparam int DEPTH = LPR * MAX_READ;
  localparam int AW    = $clog2(DEPTH);
  localparam int LC_W  = $clog2(LPR);
  localparam int SPL   = CL / SYM_W;
  localparam int HW    = CL / 2;
  localparam int SPH   = SPL / 2;
  localparam int SPW   = 64 / SYM_W;
  localparam int WPH   = HW / 64;
  localparam int LN_W  = READ_LINES > 1 ? $clog2(READ_LINES) : 1;
  localparam int WI_W  = WPH > 1 ? $clog2(WPH) : 1;
  localparam int SI_W  = SPW > 1 ? $clog2(SPW) : 1;
  localparam logic [AW-1:0] A_PRM0 = AW'(READ_LINES);
  localparam logic [AW-1:0] A_IK0  = AW'(LPR - 1);

  function automatic logic [AW-1:0] addr(
    input logic [RN_W-1:0] rn,
    input int              ln
  );
    return AW'(int'(rn) * LPR + ln);
  endfunction

  logic [CL-1:0]   r_mem [DEPTH];
  logic [RN_W:0]   r_bsize;
  logic [RN_W:0]   r_read_cnt;
  logic [LC_W-1:0] r_line_cnt;
  logic [RN_W:0]   r_ptr;
  logic            r_done;
  logic            r_ovf;

  logic            w_room;
  logic            w_wr;
  logic            w_valid;
  logic [AW-1:0]   w_pa;
  logic [AW-1:0]   w_ia;

  assign w_room = r_read_cnt < r_bsize;
  assign w_wr   = bus.load_valid && !bus.batch_start
                  && w_room;
  assign w_valid = r_done && (r_ptr < r_bsize);

  // Load counters, batch restart and dispatch pointer.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_bsize    <= '0;
      r_read_cnt <= '0;
      r_line_cnt <= '0;
      r_ptr      <= '0;
      r_done     <= 1'b0;
      r_ovf      <= 1'b0;
    end else if (bus.batch_start) begin
      r_bsize    <= bus.batch_size;
      r_read_cnt <= '0;
      r_line_cnt <= '0;
      r_ptr      <= '0;
      r_done     <= 1'b0;
      r_ovf      <= 1'b0;
    end else begin
      if (w_wr) begin
        if (r_line_cnt == LC_W'(LPR - 1)) begin
          r_line_cnt <= '0;
          r_read_cnt <= r_read_cnt + 1'b1;
        end else begin
          r_line_cnt <= r_line_cnt + 1'b1;
        end
      end
      if (bus.load_valid && !w_room)
        r_ovf <= 1'b1;
      r_done <= (r_bsize != '0)
                && (r_read_cnt == r_bsize);
      if (w_valid && bus.new_read_ack)
        r_ptr <= r_ptr + 1'b1;
    end
  end

  // Line storage; contents survive batch restarts.
  always_ff @(posedge clk) begin
    if (!reset && w_wr)
      r_mem[addr(r_read_cnt[RN_W-1:0],
                 int'(r_line_cnt))] <= bus.load_data;
  end

  assign w_pa = addr(r_ptr[RN_W-1:0], READ_LINES);
  assign w_ia = addr(r_ptr[RN_W-1:0], LPR - 1);

  assign bus.load_done      = r_done;
  assign bus.load_overflow  = r_ovf;
  assign bus.new_read_valid = w_valid;
  assign bus.all_dispatched = r_done
                              && (r_ptr == r_bsize);

  // Current read's start state, all-ones when idle.
  always_comb begin
    bus.new_read_num  = '1;
    bus.new_forward_i = '1;
    bus.new_ik_x0     = '1;
    bus.new_ik_x1     = '1;
    bus.new_ik_x2     = '1;
    bus.new_ik_info   = '1;
    if (w_valid) begin
      bus.new_read_num  = r_ptr[RN_W-1:0];
      bus.new_forward_i = r_mem[w_pa][6:0];
      bus.new_ik_x0     = r_mem[w_ia][63:0];
      bus.new_ik_x1     = r_mem[w_ia][127:64];
      bus.new_ik_x2     = r_mem[w_ia][191:128];
      bus.new_ik_info   = r_mem[w_ia][255:192];
    end
  end

  assign primary = r_mem[A_PRM0][191:128];
  assign L2_0    = r_mem[A_IK0][319:256];
  assign L2_1    = r_mem[A_IK0][383:320];
  assign L2_2    = r_mem[A_IK0][447:384];
  assign L2_3    = r_mem[A_IK0][511:448];

  for (genvar g = 0; g < NQ; g++) begin : g_q
    logic [5:0]       w_st;
    logic [POS_W-1:0] w_pos;
    logic [RN_W-1:0]  w_rn;
    logic             w_skip;
    logic [LN_W-1:0]  w_ln;
    logic             w_hf;
    logic [WI_W-1:0]  w_wi;
    logic [SI_W-1:0]  w_si;
    logic [CL-1:0]    w_ld;

    logic [HW-1:0]    r_s1_half;
    logic [WI_W-1:0]  r_s1_wi;
    logic [SI_W-1:0]  r_s1_si;
    logic             r_s1_skip;
    logic [5:0]       r_s1_st;
    logic [63:0]      r_s2_word;
    logic [SI_W-1:0]  r_s2_si;
    logic             r_s2_skip;
    logic [5:0]       r_s2_st;
    logic [SYM_W-1:0] r_sym;
    logic [5:0]       r_sto;

    assign w_st  = q_status[g*6 +: 6];
    assign w_pos = q_position[g*POS_W +: POS_W];
    assign w_rn  = q_read_num[g*RN_W +: RN_W];

    assign w_skip = (w_st == 6'h30) || (w_st == 6'h02)
                    || (w_st == 6'h06)
                    || ({1'b0, w_pos}
                        >= (POS_W + 1)'(SYMS));

    // Split the symbol index into line/half/word/symbol.
    always_comb begin
      w_ln = LN_W'(int'(w_pos) / SPL);
      w_hf = (int'(w_pos) % SPL) >= SPH;
      w_wi = WI_W'((int'(w_pos) % SPH) / SPW);
      w_si = SI_W'(int'(w_pos) % SPW);
    end

    assign w_ld = r_mem[addr(w_rn, int'(w_ln))];

    // Three-stage lookup: half line, word, symbol.
    always_ff @(posedge clk) begin
      if (reset) begin
        r_s1_half <= '0;
        r_s1_wi   <= '0;
        r_s1_si   <= '0;
        r_s1_skip <= 1'b1;
        r_s1_st   <= 6'h30;
        r_s2_word <= '0;
        r_s2_si   <= '0;
        r_s2_skip <= 1'b1;
        r_s2_st   <= 6'h30;
        r_sym     <= '1;
        r_sto     <= 6'h30;
      end else begin
        r_s1_half <= w_hf ? w_ld[CL-1:HW]
                          : w_ld[HW-1:0];
        r_s1_wi   <= w_wi;
        r_s1_si   <= w_si;
        r_s1_skip <= w_skip;
        r_s1_st   <= w_st;
        r_s2_word <= r_s1_half[int'(r_s1_wi)*64 +: 64];
        r_s2_si   <= r_s1_si;
        r_s2_skip <= r_s1_skip;
        r_s2_st   <= r_s1_st;
        r_sym     <= r_s2_skip ? '1
                     : r_s2_word[int'(r_s2_si)*SYM_W
                                 +: SYM_W];
        r_sto     <= r_s2_st;
      end
    end

    assign q_symbol[g*SYM_W +: SYM_W] = r_sym;
    assign q_status_out[g*6 +: 6]     = r_sto;
  end

endmodule

// File: tb/tb_read_store_mc.sv
// Directed bench for read_store_mc: load, dispatch,
// query pipeline, overflow, restart and reset.
module tb_read_store_mc;
  localparam int CL    = 512;
  localparam int RN_W  = 9;
  localparam int POS_W = 7;
  localparam int NQ    = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [63:0] primary, L2_0, L2_1, L2_2, L2_3;
  logic [NQ*6-1:0]     q_status;
  logic [NQ*POS_W-1:0] q_position;
  logic [NQ*RN_W-1:0]  q_read_num;
  logic [NQ*8-1:0]     q_symbol;
  logic [NQ*6-1:0]     q_status_out;

  int ncmp = 0;
  int nerr = 0;

  read_store_mc_if #(.CL(CL), .RN_W(RN_W)) bus ();

  read_store_mc u_dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus),
    .primary      (primary),
    .L2_0         (L2_0),
    .L2_1         (L2_1),
    .L2_2         (L2_2),
    .L2_3         (L2_3),
    .q_status     (q_status),
    .q_position   (q_position),
    .q_read_num   (q_read_num),
    .q_symbol     (q_symbol),
    .q_status_out (q_status_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: got %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [CL-1:0] beat(int kind, int i);
    logic [CL-1:0] d;
    d = {8{64'(i)}};
    if (kind == 1 && (i == 8 || i == 9))
      for (int b = 0; b < 64; b++)
        d[b*8 +: 8] = 8'(b + (i == 9 ? 64 : 0));
    if (kind == 2)
      d = {64{8'(i) | 8'h80}};
    return d;
  endfunction

  task automatic idle_q;
    q_status   = {6'h30, 6'h30};
    q_position = '0;
    q_read_num = '0;
  endtask

  task automatic start_batch(input int bs);
    bus.batch_start = 1'b1;
    bus.batch_size  = 10'(bs);
    tick();
    bus.batch_start = 1'b0;
  endtask

  task automatic beats(input int n, input int kind);
    for (int i = 0; i < n; i++) begin
      bus.load_valid = 1'b1;
      bus.load_data  = beat(kind, i);
      tick();
    end
    bus.load_valid = 1'b0;
  endtask

  task automatic q0(input int rn, input int pos,
                    output logic [7:0] s);
    q_status[5:0]   = 6'h11;
    q_position[6:0] = 7'(pos);
    q_read_num[8:0] = 9'(rn);
    repeat (3) tick();
    s = q_symbol[7:0];
    idle_q();
  endtask

  initial begin
    logic [7:0] s;
    int p0[4];
    logic [5:0] s1[4];
    logic [7:0] e0[4];
    logic [7:0] e1[4];
    p0 = '{0, 63, 64, 127};
    e0 = '{8'd0, 8'd63, 8'd64, 8'd127};
    s1 = '{6'h30, 6'h02, 6'h06, 6'h11};
    e1 = '{8'hFF, 8'hFF, 8'hFF, 8'h01};

    bus.batch_start  = 1'b0;
    bus.batch_size   = '0;
    bus.load_valid   = 1'b0;
    bus.load_data    = '0;
    bus.new_read_ack = 1'b0;
    idle_q();
    repeat (2) tick();
    chk("rst_done", 64'(bus.load_done), 64'd0);
    chk("rst_ovf", 64'(bus.load_overflow), 64'd0);
    chk("rst_valid", 64'(bus.new_read_valid), 64'd0);
    chk("rst_alld", 64'(bus.all_dispatched), 64'd0);
    chk("rst_sym", 64'(q_symbol), 64'hFFFF);
    chk("rst_sto", 64'(q_status_out), 64'hC30);
    reset = 1'b0;
    tick();

    start_batch(3);
    beats(12, 0);
    chk("done_early", 64'(bus.load_done), 64'd0);
    tick();
    chk("done", 64'(bus.load_done), 64'd1);
    chk("valid0", 64'(bus.new_read_valid), 64'd1);
    chk("num0", 64'(bus.new_read_num), 64'd0);
    chk("primary", primary, 64'd2);
    chk("L2_0", L2_0, 64'd3);
    chk("L2_3", L2_3, 64'd3);

    bus.new_read_ack = 1'b1;
    chk("fwd0", 64'(bus.new_forward_i), 64'd2);
    tick();
    chk("num1", 64'(bus.new_read_num), 64'd1);
    chk("fwd1", 64'(bus.new_forward_i), 64'd6);
    chk("ikx0_1", bus.new_ik_x0, 64'd7);
    chk("ikinfo_1", bus.new_ik_info, 64'd7);
    tick();
    chk("num2", 64'(bus.new_read_num), 64'd2);
    chk("fwd2", 64'(bus.new_forward_i), 64'd10);
    chk("ikx2_2", bus.new_ik_x2, 64'd11);
    tick();
    chk("valid_end", 64'(bus.new_read_valid), 64'd0);
    chk("alld", 64'(bus.all_dispatched), 64'd1);
    chk("num_idle", 64'(bus.new_read_num), 64'h1FF);
    chk("ik_idle", bus.new_ik_x0, 64'hFFFF_FFFF_FFFF_FFFF);
    tick();
    chk("alld_hold", 64'(bus.all_dispatched), 64'd1);
    bus.new_read_ack = 1'b0;

    bus.load_valid = 1'b1;
    bus.load_data  = '1;
    tick();
    bus.load_valid = 1'b0;
    chk("ovf", 64'(bus.load_overflow), 64'd1);
    q0(2, 0, s);
    chk("r2_p0", 64'(s), 64'd8);
    q0(2, 1, s);
    chk("r2_p1", 64'(s), 64'd0);
    q0(2, 8, s);
    chk("r2_p8", 64'(s), 64'd8);
    q0(2, 64, s);
    chk("r2_p64", 64'(s), 64'd9);

    start_batch(1);
    chk("rs_done", 64'(bus.load_done), 64'd0);
    chk("rs_ovf", 64'(bus.load_overflow), 64'd0);
    chk("rs_alld", 64'(bus.all_dispatched), 64'd0);
    beats(4, 0);
    tick();
    chk("rs_done1", 64'(bus.load_done), 64'd1);
    chk("rs_valid", 64'(bus.new_read_valid), 64'd1);
    bus.new_read_ack = 1'b1;
    tick();
    bus.new_read_ack = 1'b0;
    chk("rs_alld1", 64'(bus.all_dispatched), 64'd1);

    start_batch(3);
    beats(12, 1);
    tick();
    chk("pat_done", 64'(bus.load_done), 64'd1);
    for (int j = 0; j < 6; j++) begin
      if (j < 4) begin
        q_status   = {s1[j], 6'h11};
        q_position = {(j == 3 ? 7'd1 : 7'd5),
                      7'(p0[j])};
        q_read_num = {9'd2, 9'd2};
      end else begin
        idle_q();
      end
      tick();
      if (j >= 2) begin
        chk("q0_sym", 64'(q_symbol[7:0]),
            64'(e0[j-2]));
        chk("q0_st", 64'(q_status_out[5:0]), 64'h11);
        chk("q1_sym", 64'(q_symbol[15:8]),
            64'(e1[j-2]));
        chk("q1_st", 64'(q_status_out[11:6]),
            64'(s1[j-2]));
      end
    end

    bus.new_read_ack = 1'b1;
    bus.load_valid   = 1'b1;
    q_status[5:0]    = 6'h11;
    tick();
    chk("md_num", 64'(bus.new_read_num), 64'd1);
    chk("md_ovf", 64'(bus.load_overflow), 64'd1);
    bus.load_valid = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    bus.new_read_ack = 1'b0;
    idle_q();
    chk("mr_done", 64'(bus.load_done), 64'd0);
    chk("mr_ovf", 64'(bus.load_overflow), 64'd0);
    chk("mr_valid", 64'(bus.new_read_valid), 64'd0);
    chk("mr_alld", 64'(bus.all_dispatched), 64'd0);
    chk("mr_sym", 64'(q_symbol), 64'hFFFF);
    chk("mr_sto", 64'(q_status_out), 64'hC30);

    start_batch(3);
    for (int i = 0; i < 12; i++) begin
      bus.load_valid = 1'b1;
      bus.load_data  = beat(2, i);
      if (i == 8 || i == 9) begin
        q_status[5:0]   = 6'h11;
        q_position[6:0] = 7'd0;
        q_read_num[8:0] = 9'd2;
      end else begin
        idle_q();
      end
      tick();
      if (i == 10)
        chk("wr_old", 64'(q_symbol[7:0]), 64'h00);
      if (i == 11)
        chk("wr_new", 64'(q_symbol[7:0]), 64'h88);
    end
    bus.load_valid = 1'b0;
    idle_q();
    tick();
    chk("rl_done", 64'(bus.load_done), 64'd1);
    chk("rl_valid", 64'(bus.new_read_valid), 64'd1);
    chk("rl_num", 64'(bus.new_read_num), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             ncmp, nerr);
    $finish;
  end
endmodule
